// File: rtl/regfile_wb_scheduler.sv
// Writeback arbiter and busy-register scoreboard for the 32x32 register file.
// Optional operand bypass from the registered write port: define RF_WB_BYPASS_EN.
module regfile_wb_scheduler #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rs1,
    input  logic [ADDR_W-1:0] iss_rs2,
    input  logic [ADDR_W-1:0] iss_rd,
    output logic              iss_stall,
    input  logic              wb0_valid,
    input  logic [ADDR_W-1:0] wb0_rd,
    input  logic [DATA_W-1:0] wb0_data,
    output logic              wb0_ready,
    input  logic              wb1_valid,
    input  logic [ADDR_W-1:0] wb1_rd,
    input  logic [DATA_W-1:0] wb1_data,
    output logic              wb1_ready,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_rd,
    output logic [DATA_W-1:0] rf_wd,
    output logic [CNT_W-1:0]  conf_cnt
`ifdef RF_WB_BYPASS_EN
    ,
    output logic              byp1_hit,
    output logic              byp2_hit,
    output logic [DATA_W-1:0] byp_data
`endif
);

    localparam int NREG = 2 ** ADDR_W;

    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_nxt;
    logic              pref1;
    logic              grant0;
    logic              grant1;
    logic              wr_go;
    logic [ADDR_W-1:0] wr_rd;
    logic [DATA_W-1:0] wr_data;
    logic              src1_busy;
    logic              src2_busy;
    logic              dst_busy;

    // pref1 set means wb0 won last, so wb1 wins the next collision
    assign grant0    = wb0_valid && (!wb1_valid || !pref1);
    assign grant1    = wb1_valid && (!wb0_valid || pref1);
    assign wb0_ready = grant0;
    assign wb1_ready = grant1;

    assign wr_rd   = grant0 ? wb0_rd   : wb1_rd;
    assign wr_data = grant0 ? wb0_data : wb1_data;
    assign wr_go   = (grant0 || grant1) && (wr_rd != '0);

`ifdef RF_WB_BYPASS_EN
    assign byp1_hit  = rf_we && (rf_rd != '0) && (rf_rd == iss_rs1);
    assign byp2_hit  = rf_we && (rf_rd != '0) && (rf_rd == iss_rs2);
    assign byp_data  = rf_wd;
    assign src1_busy = busy[iss_rs1] && !byp1_hit;
    assign src2_busy = busy[iss_rs2] && !byp2_hit;
`else
    assign src1_busy = busy[iss_rs1];
    assign src2_busy = busy[iss_rs2];
`endif
    assign dst_busy  = busy[iss_rd];
    assign iss_stall = iss_valid && (src1_busy || src2_busy || dst_busy);

    // Clear first so a same-cycle new producer keeps the register marked
    always_comb begin
        busy_nxt = busy;
        if (rf_we) begin
            busy_nxt[rf_rd] = 1'b0;
        end
        if (iss_valid && !iss_stall && (iss_rd != '0)) begin
            busy_nxt[iss_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy     <= '0;
            pref1    <= 1'b0;
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wd    <= '0;
            conf_cnt <= '0;
        end else begin
            busy  <= busy_nxt;
            rf_we <= wr_go;
            if (wr_go) begin
                rf_rd <= wr_rd;
                rf_wd <= wr_data;
            end
            if (grant0) begin
                pref1 <= 1'b1;
            end else if (grant1) begin
                pref1 <= 1'b0;
            end
            if (wb0_valid && wb1_valid && (conf_cnt != {CNT_W{1'b1}})) begin
                conf_cnt <= conf_cnt + CNT_W'(1);
            end
        end
    end

endmodule
